// File: rtl/octave_pkg.sv
// Shared definitions for the octave scan sequencer: FSM encoding,
// coordinate width and the per-octave window-border helper.
package octave_pkg;

    localparam int COORD_W = 10;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_FLUSH  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    // Width of the fill border of octave k, in octave-0 pixels.
    function automatic logic [10:0] oct_border(input int win_radi, input int k);
        return 11'(win_radi << k);
    endfunction

endpackage

// File: rtl/octave_gate.sv
// Decimation and valid-region compare for a single octave. Operates on the
// coordinate of the current strobe; the caller registers the results.
module octave_gate
    import octave_pkg::*;
#(
    parameter int K        = 0,
    parameter int FRAME_H  = 480,
    parameter int WIN_RADI = 9
) (
    input  logic               stb_i,
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    output logic               en_o,
    output logic               valid_o
);

    localparam logic [10:0]        BORDER = oct_border(WIN_RADI, K);
    localparam logic [10:0]        Y_END  = 11'(FRAME_H) + BORDER;
    localparam logic [COORD_W-1:0] MASK   = COORD_W'((1 << K) - 1);

    logic [10:0] x_w;
    logic [10:0] y_w;

    assign x_w     = {1'b0, x_i};
    assign y_w     = {1'b0, y_i};
    assign en_o    = stb_i && ((x_i & MASK) == '0) && ((y_i & MASK) == '0);
    assign valid_o = en_o && (y_w >= BORDER) && (x_w >= BORDER) && (y_w < Y_END);

endmodule

// File: rtl/octave_scan_sequencer.sv
// Front-end sequencer: raster coordinates, per-octave enables/valids and
// zero-pixel flush after each frame so the deepest octave drains.
module octave_scan_sequencer
    import octave_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FRAME_W    = 640,
    parameter int FRAME_H    = 480,
    parameter int OCT_N      = 4,
    parameter int WIN_RADI   = 9,
    parameter int FLUSH_ROWS = WIN_RADI << (OCT_N - 1)
) (
    input  logic               clk,
    input  logic               rst_p,
    input  logic               sof,
    input  logic               pix_valid,
    input  logic [DATA_W-1:0]  pix_in,
    output logic               pix_en,
    output logic [DATA_W-1:0]  pix_out,
    output logic [COORD_W-1:0] X,
    output logic [COORD_W-1:0] Y,
    output logic [OCT_N-1:0]   oct_en,
    output logic [OCT_N-1:0]   oct_valid,
    output logic               busy,
    output logic               frame_done,
    output logic               err
);

    localparam logic [COORD_W-1:0] LAST_COL  = COORD_W'(FRAME_W - 1);
    localparam logic [COORD_W-1:0] LAST_ROW  = COORD_W'(FRAME_H - 1);
    localparam logic [COORD_W-1:0] LAST_FROW = COORD_W'(FRAME_H + FLUSH_ROWS - 1);
    localparam logic [COORD_W-1:0] ONE       = COORD_W'(1);

    logic [1:0]         state_q, state_d;
    logic [COORD_W-1:0] col_q, col_d;
    logic [COORD_W-1:0] row_q, row_d;
    logic               err_q, err_d;

    logic               pix_en_q;
    logic [DATA_W-1:0]  pix_q;
    logic [COORD_W-1:0] x_q, y_q;
    logic [OCT_N-1:0]   oct_en_q, oct_valid_q;

    // Strobe of this cycle and its coordinate
    logic               stb;
    logic               flush;
    logic [COORD_W-1:0] cx, cy;
    logic [OCT_N-1:0]   gate_en, gate_vld;

    // Next-state: strobe generation, coordinate advance, FSM and error flag
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        err_d   = err_q;
        stb     = 1'b0;
        flush   = 1'b0;
        cx      = col_q;
        cy      = row_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (sof && pix_valid) begin
                    stb     = 1'b1;
                    cx      = '0;
                    cy      = '0;
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (pix_valid) begin
                    stb = 1'b1;
                    if (sof) begin
                        // Mid-frame start: restart the raster with this pixel
                        cx    = '0;
                        cy    = '0;
                        err_d = 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                stb   = 1'b1;
                flush = 1'b1;
                if (pix_valid || sof) err_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (stb) begin
            if (cx == LAST_COL) begin
                col_d = '0;
                row_d = cy + ONE;
            end else begin
                col_d = cx + ONE;
                row_d = cy;
            end
            if (!flush && cx == LAST_COL && cy == LAST_ROW) state_d = S_FLUSH;
            if (flush && cx == LAST_COL && cy == LAST_FROW) state_d = S_DONE;
        end
    end

    for (genvar k = 0; k < OCT_N; k++) begin : g_oct
        octave_gate #(
            .K        (k),
            .FRAME_H  (FRAME_H),
            .WIN_RADI (WIN_RADI)
        ) u_gate (
            .stb_i   (stb),
            .x_i     (cx),
            .y_i     (cy),
            .en_o    (gate_en[k]),
            .valid_o (gate_vld[k])
        );
    end

    // State, counters and one-cycle-latency output registers
    always_ff @(posedge clk) begin
        if (rst_p) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            err_q       <= 1'b0;
            pix_en_q    <= 1'b0;
            pix_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            oct_en_q    <= '0;
            oct_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            err_q       <= err_d;
            pix_en_q    <= stb;
            oct_en_q    <= gate_en;
            oct_valid_q <= gate_vld;
            if (stb) begin
                x_q   <= cx;
                y_q   <= cy;
                pix_q <= flush ? '0 : pix_in;
            end
        end
    end

    assign pix_en     = pix_en_q;
    assign pix_out    = pix_q;
    assign X          = x_q;
    assign Y          = y_q;
    assign oct_en     = oct_en_q;
    assign oct_valid  = oct_valid_q;
    assign busy       = (state_q == S_ACTIVE) || (state_q == S_FLUSH);
    assign frame_done = (state_q == S_DONE);
    assign err        = err_q;

endmodule

// File: tb/tb_octave_scan_sequencer.sv
// Directed bench for octave_scan_sequencer on an 8x4 frame, 2 octaves,
// window radius 1 (two flush rows).
module tb_octave_scan_sequencer;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int ON = 2;
    localparam int WR = 1;

    logic       clk = 1'b0;
    logic       rst_p;
    logic       sof;
    logic       pix_valid;
    logic [7:0] pix_in;
    logic       pix_en;
    logic [7:0] pix_out;
    logic [9:0] X;
    logic [9:0] Y;
    logic [1:0] oct_en;
    logic [1:0] oct_valid;
    logic       busy;
    logic       frame_done;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    octave_scan_sequencer #(
        .DATA_W   (8),
        .FRAME_W  (W),
        .FRAME_H  (H),
        .OCT_N    (ON),
        .WIN_RADI (WR)
    ) dut (
        .clk        (clk),
        .rst_p      (rst_p),
        .sof        (sof),
        .pix_valid  (pix_valid),
        .pix_in     (pix_in),
        .pix_en     (pix_en),
        .pix_out    (pix_out),
        .X          (X),
        .Y          (Y),
        .oct_en     (oct_en),
        .oct_valid  (oct_valid),
        .busy       (busy),
        .frame_done (frame_done),
        .err        (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit s, input logic [7:0] p);
        sof       = s;
        pix_valid = 1'b1;
        pix_in    = p;
        tick();
        sof       = 1'b0;
        pix_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_p = 1'b1;
        tick();
        rst_p = 1'b0;
    endtask

    // Hand-derived expectations for the 8x4 / r=1 / 2-octave geometry
    function automatic logic [1:0] exp_oen(input int x, input int y);
        return {((x % 2) == 0) && ((y % 2) == 0), 1'b1};
    endfunction

    function automatic logic [1:0] exp_ov(input int x, input int y);
        logic v0, v1;
        v0 = (x >= 1) && (y >= 1) && (y <= 4);
        v1 = ((x % 2) == 0) && (x >= 2) && ((y == 2) || (y == 4));
        return {v1, v0};
    endfunction

    task automatic chk_px(input string tag, input int x, input int y, input int p);
        chk({tag, "_en"}, pix_en, 1);
        chk({tag, "_x"}, X, x);
        chk({tag, "_y"}, Y, y);
        chk({tag, "_pix"}, pix_out, p);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_en"}, pix_en, 0);
        chk({tag, "_x"}, X, 0);
        chk({tag, "_y"}, Y, 0);
        chk({tag, "_pix"}, pix_out, 0);
        chk({tag, "_oen"}, oct_en, 0);
        chk({tag, "_ov"}, oct_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, frame_done, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    task automatic active_frame();
        for (int i = 0; i < W * H; i++) begin
            push(i == 0, 8'(i + 10));
            chk_px("act", i % W, i / W, i + 10);
            chk("act_oen", oct_en, exp_oen(i % W, i / W));
            chk("act_ov", oct_valid, exp_ov(i % W, i / W));
            chk("act_busy", busy, 1);
            chk("act_done", frame_done, 0);
        end
    endtask

    task automatic flush_run(input bit pv);
        for (int j = 0; j < 2 * W; j++) begin
            if (pv) begin
                pix_valid = 1'b1;
                pix_in    = 8'hAA;
            end
            tick();
            pix_valid = 1'b0;
            chk_px("flush", j % W, H + j / W, 0);
            chk("flush_oen", oct_en, exp_oen(j % W, H + j / W));
            chk("flush_ov", oct_valid, exp_ov(j % W, H + j / W));
            chk("flush_done", frame_done, (j == 2 * W - 1) ? 1 : 0);
            chk("flush_busy", busy, (j == 2 * W - 1) ? 0 : 1);
        end
    endtask

    initial begin
        rst_p     = 1'b1;
        sof       = 1'b0;
        pix_valid = 1'b0;
        pix_in    = '0;
        tick();
        tick();
        chk_zero("reset");
        rst_p = 1'b0;

        // pix_valid without sof in IDLE is dropped silently
        push(1'b0, 8'd55);
        chk("idle_drop_en", pix_en, 0);
        chk("idle_drop_busy", busy, 0);
        chk("idle_drop_err", err, 0);

        // Clean frame with flush
        active_frame();
        flush_run(1'b0);
        chk("clean_err", err, 0);
        tick();
        chk("post_en", pix_en, 0);
        chk("post_done", frame_done, 0);
        chk("post_busy", busy, 0);
        chk("post_x_hold", X, W - 1);
        chk("post_y_hold", Y, H + 1);

        // Gapped input: 1 on / 2 off
        for (int i = 0; i < 10; i++) begin
            push(i == 0, 8'(i + 100));
            chk_px("gap", i % W, i / W, i + 100);
            for (int g = 0; g < 2; g++) begin
                tick();
                chk("gap_off_en", pix_en, 0);
                chk("gap_off_x", X, i % W);
                chk("gap_off_y", Y, i / W);
                chk("gap_off_pix", pix_out, i + 100);
                chk("gap_off_oen", oct_en, 0);
                chk("gap_off_busy", busy, 1);
            end
        end
        do_reset();
        chk("midframe_rst_busy", busy, 0);
        chk("midframe_rst_en", pix_en, 0);

        // sof in ACTIVE at (3,1): restart, sticky err
        for (int i = 0; i < 11; i++) begin
            push(i == 0, 8'(i));
        end
        chk_px("pre_restart", 2, 1, 10);
        chk("pre_restart_err", err, 0);
        push(1'b1, 8'd99);
        chk_px("restart", 0, 0, 99);
        chk("restart_oen", oct_en, 2'b11);
        chk("restart_err", err, 1);
        for (int i = 1; i < W * H; i++) begin
            push(1'b0, 8'(i));
            chk_px("restart_run", i % W, i / W, i);
        end
        flush_run(1'b0);
        chk("restart_err_end", err, 1);
        tick();
        chk("restart_err_idle", err, 1);
        do_reset();
        chk("restart_err_rst", err, 0);

        // pix_valid during flush is ignored; then sof&pix_valid while DONE
        active_frame();
        flush_run(1'b1);
        chk("flushpv_err", err, 1);
        push(1'b1, 8'd77);
        chk_px("done_sof", 0, 0, 77);
        chk("done_sof_busy", busy, 1);
        chk("done_sof_done", frame_done, 0);
        do_reset();

        // Reset in the middle of flush
        active_frame();
        for (int j = 0; j < 5; j++) tick();
        chk("midflush_en", pix_en, 1);
        chk("midflush_pix", pix_out, 0);
        do_reset();
        chk_zero("midflush_rst");
        begin
            int done_cnt = 0;
            for (int j = 0; j < 20; j++) begin
                tick();
                if (frame_done) done_cnt++;
            end
            chk("midflush_no_done", done_cnt, 0);
        end
        push(1'b1, 8'd5);
        chk_px("fresh", 0, 0, 5);
        chk("fresh_oen", oct_en, 2'b11);
        chk("fresh_err", err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/octave_scan_sequencer.md
Name: octave_scan_sequencer

Overview:
- Front-end controller that sequences the pixel stream into the per-octave Gaussian/corner pipelines.
- Generates raster X/Y coordinates and per-octave decimated enables.
- Marks which octave outputs are valid, i.e. not inside the window-fill border.
- After the last pixel of a frame, inserts zero-valued flush pixels so the deepest octave's vertical window drains completely, then pulses frame_done.

Parameters:
- DATA_W, 8, pixel width.
- FRAME_W, 640, pixels per line (octave 0).
- FRAME_H, 480, lines per frame.
- OCT_N, 4, number of octaves driven (octave k decimates by 2^k).
- WIN_RADI, 9, vertical/horizontal window radius of the octave filter, in that octave's pixels.
- FLUSH_ROWS, WIN_RADI<<(OCT_N-1), octave-0 lines of zero pixels inserted after the frame.

Ports:
- clk  in  1  clock.
- rst_p  in  1  synchronous active-high reset.
- sof  in  1  start-of-frame strobe; qualifies the first pixel when pix_valid is high in the same cycle.
- pix_valid  in  1  input pixel strobe.
- pix_in  in  DATA_W  input pixel.
- pix_en  out  1  registered pixel strobe to octave pipelines (the en input).
- pix_out  out  DATA_W  registered pixel; 0 during flush.
- X  out  10  column of pix_out.
- Y  out  10  row of pix_out.
- oct_en  out  OCT_N  per-octave decimated enable.
- oct_valid  out  OCT_N  per-octave output-valid flag.
- busy  out  1  high in ACTIVE or FLUSH.
- frame_done  out  1  one-cycle pulse at end of flush.
- err  out  1  sticky protocol error.

Behaviour:
- Reset: state IDLE; all outputs 0; internal counters 0. Reset mid-frame or mid-flush aborts immediately; no frame_done is issued.
- States and transitions:
  - IDLE → ACTIVE on sof&pix_valid. That pixel is the first, coordinate (0,0). pix_valid without sof in IDLE is dropped; err is not set.
  - ACTIVE: each pix_valid consumes one pixel.
    - Column counter wraps at FRAME_W-1 to 0 and increments the row.
    - Pixel (FRAME_W-1, FRAME_H-1) → FLUSH.
  - FLUSH: an internal strobe fires every cycle with pixel value 0. Coordinates continue from row FRAME_H through row FRAME_H+FLUSH_ROWS-1. After the last flush pixel (column FRAME_W-1) → DONE.
  - DONE: frame_done=1 for exactly one cycle; busy=0; next state IDLE.
- Output latency: exactly 1 cycle. Strobe at cycle t gives, at t+1:
  - pix_en=1, pix_out, and X/Y = coordinate of that strobe;
  - oct_en and oct_valid from the same coordinate.
  - With no strobe, pix_en=0, oct_en=0 and oct_valid=0; X, Y and pix_out hold their values.
- oct_en[k] = pix_en & (X[k-1:0]==0) & (Y[k-1:0]==0). oct_en[0] = pix_en.
- oct_valid[k] = oct_en[k] & (Y >= WIN_RADI<<k) & (X >= WIN_RADI<<k) & (Y < FRAME_H + (WIN_RADI<<k)).
- Comparisons are unsigned at 11 bits. Elaboration constraint: FRAME_H+FLUSH_ROWS ≤ 1023 and FRAME_W ≤ 1024.
- Simultaneous events and error handling:
  - sof&pix_valid in ACTIVE: restart at (0,0) with this pixel; set err.
  - pix_valid during FLUSH: input dropped; set err. Flush strobes have priority.
  - sof during FLUSH: ignored; set err.
  - sof&pix_valid in DONE: accepted as the first pixel, and the transition goes directly to ACTIVE with frame_done still pulsing that cycle.
  - err clears only on rst_p.

Decomposition:
- Shared package octave_pkg: state encoding (IDLE, ACTIVE, FLUSH, DONE), coordinate width constant COORD_W=10, helper function for the octave border (WIN_RADI<<k).
- Sub-module octave_gate, generated once per octave: the decimation compare and the valid compare for octave k.

Test Plan (FRAME_W=8, FRAME_H=4, OCT_N=2, WIN_RADI=1 ⇒ FLUSH_ROWS=2):
- Reset then 32 continuous strobes with sof on the first:
  - first pix_en at cycle+1 with X=0, Y=0, oct_en=2'b11;
  - 32 pix_en total, then 16 flush strobes with pix_out=0 and Y=4,5;
  - frame_done exactly one cycle after the last flush strobe; busy low afterwards.
- Same frame, check oct_valid[0]:
  - high for X≥1 on rows 1..4, low on row 0 and row 5;
  - oct_valid[1] high only at even X≥2, even Y in {2,4}.
- pix_valid gaps (1 on / 2 off): coordinates advance only on strobes; pix_en toggles accordingly; X/Y hold through gaps.
- sof&pix_valid at pixel (3,1) in ACTIVE: next output X=0, Y=0; err=1 and stays high through frame end until rst_p.
- pix_valid asserted during FLUSH: ignored, flush count unchanged (still 16 strobes); err=1.
- rst_p pulsed mid-FLUSH: next cycle all outputs 0, state IDLE, no frame_done; a new sof starts cleanly at (0,0).
